// File: rtl/vx_smem_pkg.sv
// vx_smem_pkg: shared response type and sizing helpers for the
// shared-memory responder. Entry widths follow the default configuration.
package vx_smem_pkg;

  localparam int SMEM_REQS      = 4;
  localparam int SMEM_BANKS     = 4;
  localparam int SMEM_WORD_SIZE = 4;
  localparam int SMEM_SIZE      = 16384;
  localparam int SMEM_TAG_W     = 8;

  localparam int CREDIT_W = 2;
  localparam logic [CREDIT_W-1:0] CREDITS_MAX = CREDIT_W'(2);

  typedef struct packed {
    logic [SMEM_REQS-1:0]                       tmask;
    logic [SMEM_REQS-1:0][8*SMEM_WORD_SIZE-1:0] data;
    logic [SMEM_TAG_W-1:0]                      tag;
  } rsp_entry_t;

  function automatic int bank_bits(int nb);
    return $clog2(nb);
  endfunction

  function automatic int index_bits(int sz, int ws, int nb);
    return $clog2(sz / ws / nb);
  endfunction

endpackage

// File: rtl/vx_smem_bank_sel.sv
// vx_smem_bank_sel: lowest-lane-wins pick per bank.
// VX_SMEM_BCAST_EN lets same-address reads ride along with the winner.
module vx_smem_bank_sel
  import vx_smem_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 30,
  localparam int BW = bank_bits(NUM_BANKS),
  localparam int LW = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0]             valid,
  input  logic [NUM_REQS-1:0]             rw,
  input  logic [NUM_REQS-1:0][ADDR_W-1:0] addr,
  output logic [NUM_REQS-1:0]             win_mask,
  output logic [NUM_REQS-1:0]             bcast_mask,
  output logic [NUM_BANKS-1:0]            bank_vld,
  output logic [NUM_BANKS-1:0][LW-1:0]    bank_lane
);

  always_comb begin
    bank_vld  = '0;
    bank_lane = '0;
    win_mask  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = NUM_REQS-1; i >= 0; i--) begin
        if (valid[i] && addr[i][BW-1:0] == BW'(b)) begin
          bank_vld[b]  = 1'b1;
          bank_lane[b] = LW'(i);
        end
      end
      if (bank_vld[b]) win_mask[bank_lane[b]] = 1'b1;
    end
  end

`ifdef VX_SMEM_BCAST_EN
  logic [BW-1:0] bk;
  logic [LW-1:0] ln;

  // a lane in a bank always has a winner there, so ln is meaningful
  always_comb begin
    bcast_mask = '0;
    bk = '0;
    ln = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      bk = addr[i][BW-1:0];
      ln = bank_lane[bk];
      if (valid[i] && !rw[i] && !rw[ln] &&
          addr[i] == addr[ln] && !win_mask[i])
        bcast_mask[i] = 1'b1;
    end
  end
`else
  logic unused_bcast;
  assign bcast_mask   = '0;
  assign unused_bcast = ^{rw, addr};
`endif

endmodule

// File: rtl/vx_smem_responder.sv
// vx_smem_responder: banked shared memory serving per-lane dcache requests.
// Define VX_SMEM_BCAST_EN to enable same-address read broadcast.
module vx_smem_responder
  import vx_smem_pkg::*;
#(
  parameter int NUM_REQS  = SMEM_REQS,
  parameter int NUM_BANKS = SMEM_BANKS,
  parameter int WORD_SIZE = SMEM_WORD_SIZE,
  parameter int SIZE      = SMEM_SIZE,
  parameter int TAG_WIDTH = SMEM_TAG_W,
  localparam int AW = 32 - $clog2(WORD_SIZE),
  localparam int DW = 8 * WORD_SIZE
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0]                req_rw,
  input  logic [NUM_REQS-1:0][WORD_SIZE-1:0] req_byteen,
  input  logic [NUM_REQS-1:0][AW-1:0]        req_addr,
  input  logic [NUM_REQS-1:0][DW-1:0]        req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]                req_ready,
  output logic                               rsp_valid,
  output logic [NUM_REQS-1:0]                rsp_tmask,
  output logic [NUM_REQS-1:0][DW-1:0]        rsp_data,
  output logic [TAG_WIDTH-1:0]               rsp_tag,
  input  logic                               rsp_ready
);

  localparam int BW    = bank_bits(NUM_BANKS);
  localparam int IW    = index_bits(SIZE, WORD_SIZE, NUM_BANKS);
  localparam int LW    = $clog2(NUM_REQS);
  localparam int DEPTH = 1 << IW;

  logic [NUM_REQS-1:0]          win_mask;
  logic [NUM_REQS-1:0]          bcast_mask;
  logic [NUM_REQS-1:0]          fire;
  logic [NUM_REQS-1:0]          rd_fire;
  logic [NUM_BANKS-1:0]         bank_vld;
  logic [NUM_BANKS-1:0][LW-1:0] bank_lane;
  logic [CREDIT_W-1:0]          credits;
  logic                         rd_batch;
  logic                         pop;

  vx_smem_bank_sel #(
    .NUM_REQS  (NUM_REQS),
    .NUM_BANKS (NUM_BANKS),
    .ADDR_W    (AW)
  ) u_bank_sel (
    .valid      (req_valid),
    .rw         (req_rw),
    .addr       (req_addr),
    .win_mask   (win_mask),
    .bcast_mask (bcast_mask),
    .bank_vld   (bank_vld),
    .bank_lane  (bank_lane)
  );

  // write-only lanes are held off too when no credit is left
  assign req_ready = (win_mask | bcast_mask)
                   & {NUM_REQS{!reset && credits != '0}};
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_rw;
  assign rd_batch  = |rd_fire;

  logic [WORD_SIZE-1:0][7:0] mem [NUM_BANKS][DEPTH];

  logic [NUM_BANKS-1:0][IW-1:0]             bank_idx;
  logic [NUM_BANKS-1:0]                     bank_we;
  logic [NUM_BANKS-1:0][WORD_SIZE-1:0]      bank_be;
  logic [NUM_BANKS-1:0][WORD_SIZE-1:0][7:0] bank_wd;
  logic [NUM_BANKS-1:0][DW-1:0]             bank_rd;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_idx[b] = req_addr[bank_lane[b]][BW +: IW];
      bank_we[b]  = bank_vld[b] && fire[bank_lane[b]]
                 && req_rw[bank_lane[b]];
      bank_be[b]  = req_byteen[bank_lane[b]];
      bank_wd[b]  = req_data[bank_lane[b]];
      bank_rd[b]  = mem[b][bank_idx[b]];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++)
      for (int k = 0; k < WORD_SIZE; k++)
        if (bank_we[b] && bank_be[b][k])
          mem[b][bank_idx[b]][k] <= bank_wd[b][k];
  end

  rsp_entry_t push_ent;

  always_comb begin
    push_ent       = '0;
    push_ent.tmask = rd_fire;
    for (int i = 0; i < NUM_REQS; i++)
      push_ent.data[i] = bank_rd[req_addr[i][BW-1:0]];
    for (int i = NUM_REQS-1; i >= 0; i--)
      if (rd_fire[i]) push_ent.tag = req_tag[i];
  end

  rsp_entry_t fifo_q [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  assign rsp_valid = count != 2'd0;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_tmask = fifo_q[rd_ptr].tmask;
  assign rsp_data  = fifo_q[rd_ptr].data;
  assign rsp_tag   = fifo_q[rd_ptr].tag;

  // a read batch is only accepted with a free credit, so no overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      credits   <= CREDITS_MAX;
    end else begin
      if (rd_batch) begin
        fifo_q[wr_ptr] <= push_ent;
        wr_ptr         <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count   <= count + 2'(rd_batch) - 2'(pop);
      credits <= credits + CREDIT_W'(pop) - CREDIT_W'(rd_batch);
    end
  end

endmodule

// File: tb/tb_vx_smem_responder.sv
// tb_vx_smem_responder: directed vectors against a queue/array model
// of the shared-memory responder, plus hand-computed spot checks.
module tb_vx_smem_responder;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_rw;
  logic [3:0][3:0]  req_byteen;
  logic [3:0][29:0] req_addr;
  logic [3:0][31:0] req_data;
  logic [3:0][7:0]  req_tag;
  logic [3:0]       req_ready;
  logic             rsp_valid;
  logic [3:0]       rsp_tmask;
  logic [3:0][31:0] rsp_data;
  logic [7:0]       rsp_tag;
  logic             rsp_ready;

  vx_smem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_byteen (req_byteen),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_tmask  (rsp_tmask),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]       tmask;
    logic [7:0]       tag;
    logic [3:0][31:0] d;
  } ent_t;

  ent_t        exq[$];
  logic [31:0] mm[int];
  logic [3:0]  m_acc;
  logic [3:0]  exp_rdy;
  ent_t        e;
  bit          found;
  logic [31:0] wtmp;

  function automatic int key(input logic [29:0] a);
    return int'(a[11:0]);
  endfunction

  function automatic logic [31:0] mrd(input logic [29:0] a);
    return mm.exists(key(a)) ? mm[key(a)] : 32'hx;
  endfunction

  // a lane may go if no lower valid lane shares its bank
  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    int lo;
    r = '0;
    if (exq.size() >= 2) return r;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i]) begin
        lo = i;
        for (int j = i-1; j >= 0; j--)
          if (req_valid[j] && req_addr[j][1:0] == req_addr[i][1:0]) lo = j;
        if (lo == i) r[i] = 1'b1;
`ifdef VX_SMEM_BCAST_EN
        else if (!req_rw[i] && !req_rw[lo] && req_addr[lo] == req_addr[i])
          r[i] = 1'b1;
`endif
      end
    end
    return r;
  endfunction

  initial begin
    m_acc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        exq.delete();
        m_acc = '0;
      end else begin
        exp_rdy = model_ready();
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exq.size() != 0));
        if (exq.size() != 0) begin
          if (rsp_valid) begin
            chk("rsp_tmask", 32'(rsp_tmask), 32'(exq[0].tmask));
            chk("rsp_tag", 32'(rsp_tag), 32'(exq[0].tag));
            for (int i = 0; i < 4; i++)
              if (exq[0].tmask[i])
                chk("rsp_data", rsp_data[i], exq[0].d[i]);
          end
          if (rsp_ready) void'(exq.pop_front());
        end
        m_acc = req_valid & exp_rdy;
        e = '0;
        found = 0;
        e.tmask = m_acc & ~req_rw;
        for (int i = 0; i < 4; i++) begin
          e.d[i] = 32'hx;
          if (e.tmask[i]) begin
            if (!found) e.tag = req_tag[i];
            found = 1;
            e.d[i] = mrd(req_addr[i]);
          end
        end
        if (e.tmask != 0) exq.push_back(e);
        for (int i = 0; i < 4; i++) begin
          if (m_acc[i] && req_rw[i]) begin
            wtmp = mrd(req_addr[i]);
            for (int b = 0; b < 4; b++)
              if (req_byteen[i][b]) wtmp[8*b +: 8] = req_data[i][8*b +: 8];
            mm[key(req_addr[i])] = wtmp;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~m_acc;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic run_until_idle(input int budget);
    for (int c = 0; c < budget && req_valid != 0; c++) step();
    chk("drain_req", 32'(req_valid), 32'(0));
  endtask

  task automatic set_rd(input int i, input logic [29:0] a,
                        input logic [7:0] t);
    req_valid[i] = 1'b1;
    req_rw[i]    = 1'b0;
    req_addr[i]  = a;
    req_tag[i]   = t;
  endtask

  task automatic set_wr(input int i, input logic [29:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    req_valid[i]  = 1'b1;
    req_rw[i]     = 1'b1;
    req_addr[i]   = a;
    req_data[i]   = d;
    req_byteen[i] = be;
    req_tag[i]    = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  logic [3:0][31:0] conf_d;

  initial begin
    reset      = 1'b0;
    rsp_ready  = 1'b1;
    req_valid  = '0;
    req_rw     = '0;
    req_byteen = '0;
    req_addr   = '0;
    req_data   = '0;
    req_tag    = '0;
    conf_d[0]  = 32'hA0;
    conf_d[1]  = 32'hB4;
    conf_d[2]  = 32'hFFFFFFFF;
    conf_d[3]  = 32'hC;
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) set_rd(i, 30'(i), 8'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'(0));
    chk("rst_tmask", 32'(rsp_tmask), 32'(0));
    chk("rst_tag", 32'(rsp_tag), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    req_valid = '0;
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++)
      set_wr(i, 30'(i), 32'hA0 + 32'(i), 4'hF);
    step();
    set_wr(0, 30'd4, 32'hB4, 4'hF);
    set_wr(1, 30'd8, 32'hFFFFFFFF, 4'hF);
    set_wr(2, 30'd12, 32'hC, 4'hF);
    run_until_idle(6);
    chk("wr_no_rsp", 32'(rsp_valid), 32'(0));

    for (int i = 0; i < 4; i++) set_rd(i, 30'(i), 8'h10 + 8'(i));
    step();
    chk("cf_valid", 32'(rsp_valid), 32'(1));
    chk("cf_tmask", 32'(rsp_tmask), 32'hF);
    chk("cf_tag", 32'(rsp_tag), 32'h10);
    chk("cf_data0", rsp_data[0], 32'hA0);
    chk("cf_data2", rsp_data[2], 32'hA2);
    chk("cf_taken", 32'(req_valid), 32'(0));

    for (int i = 0; i < 4; i++) set_rd(i, 30'(4*i), 8'h20 + 8'(i));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("conf_tmask", 32'(rsp_tmask), 32'(1 << k));
      chk("conf_data", rsp_data[k], conf_d[k]);
      chk("conf_tag", 32'(rsp_tag), 32'h20 + 32'(k));
    end
    chk("conf_done", 32'(req_valid), 32'(0));

    for (int i = 0; i < 4; i++) set_rd(i, 30'd4, 8'h30 + 8'(i));
`ifdef VX_SMEM_BCAST_EN
    step();
    chk("bc_tmask", 32'(rsp_tmask), 32'hF);
    chk("bc_data3", rsp_data[3], 32'hB4);
    chk("bc_tag", 32'(rsp_tag), 32'h30);
`else
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bc_tmask", 32'(rsp_tmask), 32'(1 << k));
      chk("bc_data", rsp_data[k], 32'hB4);
    end
`endif
    run_until_idle(2);

    set_wr(0, 30'd5, 32'h55, 4'hF);
    set_rd(1, 30'd0, 8'h41);
    step();
    chk("mix_tmask", 32'(rsp_tmask), 32'b0010);
    chk("mix_tag", 32'(rsp_tag), 32'h41);
    chk("mix_data", rsp_data[1], 32'hA0);
    set_rd(2, 30'd5, 8'h42);
    step();
    chk("raw_tmask", 32'(rsp_tmask), 32'b0100);
    chk("raw_data", rsp_data[2], 32'h55);

    set_wr(0, 30'd8, 32'h11223344, 4'b0011);
    step();
    chk("pw_no_rsp", 32'(rsp_valid), 32'(0));
    set_rd(0, 30'd8, 8'h43);
    step();
    chk("pw_data", rsp_data[0], 32'hFFFF3344);
    idle(1);

    rsp_ready = 1'b0;
    set_rd(0, 30'd1, 8'h51);
    step();
    set_rd(1, 30'd2, 8'h52);
    step();
    set_rd(2, 30'd3, 8'h53);
    #2;
    chk("bp_ready", 32'(req_ready), 32'(0));
    chk("bp_head", 32'(rsp_tag), 32'h51);
    idle(2);
    chk("bp_held", 32'(req_valid), 32'b0100);
    rsp_ready = 1'b1;
    run_until_idle(4);
    idle(3);
    chk("bp_drained", 32'(rsp_valid), 32'(0));

    rsp_ready = 1'b0;
    set_rd(0, 30'd0, 8'h61);
    step();
    set_rd(3, 30'd3, 8'h62);
    step();
    chk("mr_buffered", 32'(rsp_valid), 32'(1));
    set_rd(1, 30'd1, 8'h66);
    reset = 1'b1;
    #1;
    chk("mr_valid", 32'(rsp_valid), 32'(0));
    chk("mr_ready", 32'(req_ready), 32'(0));
    idle(2);
    req_valid = '0;
    reset = 1'b0;
    rsp_ready = 1'b1;
    set_rd(0, 30'd8, 8'h63);
    set_rd(3, 30'd3, 8'h64);
    step();
    chk("mr_tmask", 32'(rsp_tmask), 32'b1001);
    chk("mr_tag", 32'(rsp_tag), 32'h63);
    chk("mr_keep0", rsp_data[0], 32'hFFFF3344);
    chk("mr_keep3", rsp_data[3], 32'hA3);
    idle(1);
    rsp_ready = 1'b0;
    set_rd(0, 30'd0, 8'h65);
    step();
    set_rd(1, 30'd1, 8'h67);
    step();
    chk("mr_credits", 32'(req_valid), 32'(0));
    rsp_ready = 1'b1;
    idle(3);

    for (int k = 0; k < 4; k++) begin
      req_valid = '0;
      set_rd(k, 30'(k), 8'h70 + 8'(k));
      step();
      chk("tp_valid", 32'(rsp_valid), 32'(1));
      chk("tp_tag", 32'(rsp_tag), 32'h70 + 32'(k));
    end
    req_valid = '0;
    idle(4);
    chk("end_idle", 32'(rsp_valid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
